// File: rtl/box_renderer.sv
// -----------------------------------------------------------------------------
// box_renderer
//   Redraws a square box on every game tick. It erases the box at its previous
//   position (BG_COLOUR), then draws it at the newly sampled position, one pixel
//   per clock. The plot outputs feed a VGA adapter write port directly.
//
// Ports
//   clock         system clock
//   resetn        asynchronous active-low reset
//   game_tick     tick clock, asynchronous to clock; only its rising edge is used
//   y_coordinate  box top row, sampled in LATCH
//   flying        box state, sampled in LATCH, selects the draw colour
//   plot          pixel write enable (registered)
//   plot_x/y      pixel coordinates (registered, hold while plot=0)
//   plot_colour   pixel colour (registered, holds while plot=0)
//   busy          high while a frame update is in progress
//   frame_done    one-cycle pulse when an update completes
//   state_dbg     current FSM state, for observation only
//
// Handshake: there is no back-pressure. A pixel is written on every cycle in
// which plot=1; plot_x/plot_y/plot_colour are valid exactly on those cycles.
// -----------------------------------------------------------------------------
module box_renderer #(
  parameter logic [7:0] BOX_X      = 8'd20,
  parameter int         BOX_SIZE   = 4,
  parameter logic [2:0] BG_COLOUR  = 3'b000,
  parameter logic [2:0] BOX_COLOUR = 3'b111,
  parameter logic [2:0] FLY_COLOUR = 3'b110
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       game_tick,
  input  logic [6:0] y_coordinate,
  input  logic       flying,
  output logic       plot,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  output logic [2:0] plot_colour,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_ERASE = 3'd2,
    S_DRAW  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] LAST = 3'(BOX_SIZE - 1);

  state_t      state, state_next;
  logic        tick_sync1, tick_sync2, tick_sync2_d;
  logic        tick_rise;
  logic        pending;
  logic [2:0]  row, col;
  logic [6:0]  new_y, old_y;
  logic        new_fly, old_valid;
  logic        last_pixel;
  logic        in_slot;
  logic        visible;
  logic [6:0]  base_y;
  logic [7:0]  row_sum;
  logic [2:0]  pix_colour;

  assign state_dbg = state;

  // Two-flop synchroniser plus a registered copy for edge detection.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick_sync1   <= 1'b0;
      tick_sync2   <= 1'b0;
      tick_sync2_d <= 1'b0;
    end else begin
      tick_sync1   <= game_tick;
      tick_sync2   <= tick_sync1;
      tick_sync2_d <= tick_sync2;
    end
  end

  assign tick_rise  = tick_sync2 & ~tick_sync2_d;
  assign last_pixel = (row == LAST) && (col == LAST);

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (tick_rise || pending) state_next = S_LATCH;
      S_LATCH: state_next = old_valid ? S_ERASE : S_DRAW;
      S_ERASE: if (last_pixel) state_next = S_DRAW;
      S_DRAW:  if (last_pixel) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // A tick arriving while a frame is in flight (including DONE) is remembered
  // once; any further ticks in the same frame collapse into it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending <= 1'b0;
    end else if (state == S_IDLE) begin
      pending <= 1'b0;
    end else if (tick_rise) begin
      pending <= 1'b1;
    end
  end

  // Row-major pixel counters; they wrap to 0,0 at the end of each pass so the
  // DRAW pass starts cleared after ERASE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      row <= '0;
      col <= '0;
    end else if (state == S_ERASE || state == S_DRAW) begin
      if (col == LAST) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
    end else begin
      row <= '0;
      col <= '0;
    end
  end

  // Frame position/colour bookkeeping
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      new_y     <= '0;
      new_fly   <= 1'b0;
      old_y     <= '0;
      old_valid <= 1'b0;
    end else begin
      if (state == S_LATCH) begin
        new_y   <= y_coordinate;
        new_fly <= flying;
      end
      if (state == S_DONE) begin
        old_y     <= new_y;
        old_valid <= 1'b1;
      end
    end
  end

  // Current pixel. The row sum is 8 bits wide so rows past 127 cannot wrap
  // back onto the visible screen.
  always_comb begin
    in_slot    = (state == S_ERASE) || (state == S_DRAW);
    base_y     = (state == S_ERASE) ? old_y : new_y;
    row_sum    = {1'b0, base_y} + {5'b0, row};
    visible    = in_slot && (row_sum <= 8'd119);
    pix_colour = BG_COLOUR;
    if (state == S_DRAW) pix_colour = new_fly ? FLY_COLOUR : BOX_COLOUR;
  end

  // Registered outputs; coordinates and colour only move on visible pixels.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      plot        <= 1'b0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      plot       <= visible;
      busy       <= (state != S_IDLE);
      frame_done <= (state == S_DONE);
      if (visible) begin
        plot_x      <= BOX_X + {5'b0, col};
        plot_y      <= row_sum[6:0];
        plot_colour <= pix_colour;
      end
    end
  end

endmodule

// File: tb/tb_box_renderer.sv
module tb_box_renderer;

  logic       clock;
  logic       resetn;
  logic       game_tick;
  logic [6:0] y_coordinate;
  logic       flying;
  logic       plot;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       busy;
  logic       frame_done;
  logic [2:0] state_dbg;

  box_renderer dut (
    .clock        (clock),
    .resetn       (resetn),
    .game_tick    (game_tick),
    .y_coordinate (y_coordinate),
    .flying       (flying),
    .plot         (plot),
    .plot_x       (plot_x),
    .plot_y       (plot_y),
    .plot_colour  (plot_colour),
    .busy         (busy),
    .frame_done   (frame_done),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #10 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [17:0] exp_q[$];   // {x[7:0], y[6:0], colour[2:0]}
  int checks     = 0;
  int failures   = 0;
  int frame_cnt  = 0;
  int slot_cnt   = 0;
  int plot_cnt   = 0;
  int last_slots = 0;
  int last_plots = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Expected pixels of one box pass, row-major, clipped rows omitted.
  task automatic push_box(input int y, input int colour);
    logic [7:0]  px;
    logic [6:0]  py;
    logic [2:0]  pc;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (y + r <= 119) begin
          px = 8'(20 + c);
          py = 7'(y + r);
          pc = 3'(colour);
          exp_q.push_back({px, py, pc});
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [17:0] exp;
    if (!resetn) begin
      slot_cnt = 0;
      plot_cnt = 0;
    end else begin
      if (plot) begin
        plot_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, expected no plot",
                   plot_x, plot_y, plot_colour);
        end else begin
          exp = exp_q.pop_front();
          if ({plot_x, plot_y, plot_colour} != exp) begin
            failures++;
            $display("FAIL pixel: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                     plot_x, plot_y, plot_colour, exp[17:10], exp[9:3], exp[2:0]);
          end
        end
      end
      if (busy && !frame_done) slot_cnt++;
      if (frame_done) begin
        last_slots = slot_cnt - 1;  // one busy cycle is the LATCH cycle
        last_plots = plot_cnt;
        slot_cnt   = 0;
        plot_cnt   = 0;
        frame_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_tick();
    @(negedge clock);
    game_tick = 1'b1;
    repeat (3) @(negedge clock);
    game_tick = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_frame(input string name, input int exp_slots, input int exp_plots,
                            input bit check_q);
    int start;
    bit seen;
    start = frame_cnt;
    seen  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      #1;
      if (frame_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_frame_done_seen"}, int'(seen), 1);
    if (seen) begin
      check({name, "_slots"}, last_slots, exp_slots);
      check({name, "_plots"}, last_plots, exp_plots);
      if (check_q) check({name, "_queue_left"}, exp_q.size(), 0);
    end
  endtask

  task automatic wait_busy(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock);
      #1;
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_busy_seen"}, int'(seen), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int start;
    bit hit;

    resetn       = 1'b0;
    game_tick    = 1'b0;
    y_coordinate = '0;
    flying       = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_plot_x", int'(plot_x), 0);
    check("rst_plot_y", int'(plot_y), 0);
    check("rst_plot_colour", int'(plot_colour), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_state", int'(state_dbg), 0);

    // 1: first frame, draw only, with latency measurement
    y_coordinate = 7'd60;
    flying       = 1'b0;
    push_box(60, 7);
    @(negedge clock);
    game_tick = 1'b1;
    lat = 0;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      lat++;
      #1;
      if (plot) begin
        hit = 1'b1;
        break;
      end
    end
    check("t1_first_plot_edge", hit ? lat : -1, 5);
    @(negedge clock);
    game_tick = 1'b0;
    wait_frame("t1", 16, 16, 1'b1);
    @(negedge clock);
    check("t1_busy_after", int'(busy), 0);

    // 2: erase old box, draw flying box
    y_coordinate = 7'd58;
    flying       = 1'b1;
    push_box(60, 0);
    push_box(58, 6);
    pulse_tick();
    wait_frame("t2", 32, 32, 1'b1);

    // 3: bottom clipping
    y_coordinate = 7'd118;
    flying       = 1'b0;
    push_box(58, 0);
    push_box(118, 7);
    pulse_tick();
    wait_frame("t3", 32, 24, 1'b1);

    // 4: three extra ticks during one frame yield exactly one more frame
    y_coordinate = 7'd10;
    flying       = 1'b0;
    push_box(118, 0);
    push_box(10, 7);
    push_box(10, 0);
    push_box(10, 7);
    start = frame_cnt;
    pulse_tick();
    check("t4_busy_in_frame", int'(busy), 1);
    pulse_tick();
    pulse_tick();
    pulse_tick();
    wait_frame("t4a", 32, 24, 1'b0);
    wait_frame("t4b", 32, 32, 1'b1);
    repeat (60) @(negedge clock);
    check("t4_frame_count", frame_cnt - start, 2);
    check("t4_busy_idle", int'(busy), 0);

    // 5: reset while the sixth draw pixel is on the outputs
    y_coordinate = 7'd50;
    push_box(10, 0);
    for (int c = 0; c < 4; c++) exp_q.push_back({8'(20 + c), 7'd50, 3'd7});
    exp_q.push_back({8'd20, 7'd51, 3'd7});
    @(negedge clock);
    game_tick = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      if (plot_cnt >= 21) begin
        hit = 1'b1;
        break;
      end
    end
    check("t5_reached_slot", int'(hit), 1);
    check("t5_plot_before_rst", int'(plot), 1);
    resetn = 1'b0;
    #1;
    check("t5_rst_plot", int'(plot), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_queue_left", exp_q.size(), 0);
    game_tick = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    y_coordinate = 7'd40;
    push_box(40, 7);
    pulse_tick();
    wait_frame("t5", 16, 16, 1'b1);

    // 6: inputs changed after LATCH do not affect the current frame
    y_coordinate = 7'd30;
    push_box(40, 0);
    push_box(30, 7);
    @(negedge clock);
    game_tick = 1'b1;
    wait_busy("t6");
    y_coordinate = 7'd90;
    @(negedge clock);
    game_tick = 1'b0;
    wait_frame("t6a", 32, 32, 1'b1);
    push_box(30, 0);
    push_box(90, 7);
    pulse_tick();
    wait_frame("t6b", 32, 32, 1'b1);

    repeat (5) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
